// File: rtl/ncpu32k_itlb_maint.sv
// ITLB maintenance: arbitrates TLBL/TLBH write ports between MSR writes
// and a whole-TLB invalidate sweep; parks one MSR TLBL write across a sweep.
//
// Ports:
//   flush_valid/flush_ready : flush request handshake
//   flush_done              : one-cycle pulse on the last sweep write
//   busy                    : fetch must not read the TLB
//   wr_stall                : MSR TLBL writer must hold its write
//   msr_imm_tlbl_*/tlbh_*   : MSR write requests
//   tlbl_*/tlbh_*           : TLB array write ports

`ifndef NCPU_TLB_AW
`define NCPU_TLB_AW 7
`endif
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module ncpu32k_itlb_maint #(
  parameter int CONFIG_ITLB_NSETS_LOG2 = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_valid,
  output logic                    flush_ready,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    wr_stall,
  input  logic [`NCPU_TLB_AW-1:0] msr_imm_tlbl_idx,
  input  logic [`NCPU_DW-1:0]     msr_imm_tlbl_nxt,
  input  logic                    msr_imm_tlbl_we,
  input  logic [`NCPU_TLB_AW-1:0] msr_imm_tlbh_idx,
  input  logic [`NCPU_DW-1:0]     msr_imm_tlbh_nxt,
  input  logic                    msr_imm_tlbh_we,
  output logic [`NCPU_TLB_AW-1:0] tlbl_waddr,
  output logic [`NCPU_DW-1:0]     tlbl_din,
  output logic                    tlbl_we,
  output logic [`NCPU_TLB_AW-1:0] tlbh_waddr,
  output logic [`NCPU_DW-1:0]     tlbh_din,
  output logic                    tlbh_we
);

  localparam int AW = `NCPU_TLB_AW;
  localparam int DW = `NCPU_DW;
  localparam int NL = CONFIG_ITLB_NSETS_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NL-1:0]   cnt;
  logic            buf_v;
  logic [AW-1:0]   buf_idx;
  logic [DW-1:0]   buf_dat;
  logic            capture;
  logic            last;

  // A held strobe is not captured twice: buf_v blocks it.
  assign capture = (state == S_SWEEP) & msr_imm_tlbl_we & ~buf_v;
  assign last    = (state == S_SWEEP) & (cnt == {NL{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_SWEEP) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v   <= 1'b0;
      buf_idx <= '0;
      buf_dat <= '0;
    end else if (capture) begin
      buf_v   <= 1'b1;
      buf_idx <= msr_imm_tlbl_idx;
      buf_dat <= msr_imm_tlbl_nxt;
    end else if (state == S_DRAIN) begin
      buf_v   <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    flush_ready = 1'b0;
    flush_done  = 1'b0;
    tlbl_we     = msr_imm_tlbl_we;
    tlbl_waddr  = msr_imm_tlbl_idx;
    tlbl_din    = msr_imm_tlbl_nxt;
    unique case (state)
      S_IDLE: begin
        flush_ready = 1'b1;
        if (flush_valid) begin
          state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        tlbl_we    = 1'b1;
        tlbl_waddr = AW'(cnt);
        tlbl_din   = '0;
        if (last) begin
          flush_done = 1'b1;
          // A write captured on the final sweep cycle must still drain.
          state_nxt  = (buf_v | capture) ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        tlbl_we    = 1'b1;
        tlbl_waddr = buf_idx;
        tlbl_din   = buf_dat;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign wr_stall = buf_v;

  assign tlbh_we    = msr_imm_tlbh_we;
  assign tlbh_waddr = msr_imm_tlbh_idx;
  assign tlbh_din   = msr_imm_tlbh_nxt;

endmodule

// File: tb/tb_ncpu32k_itlb_maint.sv
// Self-checking bench for ncpu32k_itlb_maint with a 4-entry ITLB.
// Expected per-cycle outputs are queued as stimulus is driven.

`ifndef NCPU_TLB_AW
`define NCPU_TLB_AW 7
`endif
`ifndef NCPU_DW
`define NCPU_DW 32
`endif

module tb_ncpu32k_itlb_maint;

  localparam int AW = `NCPU_TLB_AW;
  localparam int DW = `NCPU_DW;
  localparam int OW = 2 * (1 + AW + DW) + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_valid;
  logic          flush_ready;
  logic          flush_done;
  logic          busy;
  logic          wr_stall;
  logic [AW-1:0] msr_imm_tlbl_idx;
  logic [DW-1:0] msr_imm_tlbl_nxt;
  logic          msr_imm_tlbl_we;
  logic [AW-1:0] msr_imm_tlbh_idx;
  logic [DW-1:0] msr_imm_tlbh_nxt;
  logic          msr_imm_tlbh_we;
  logic [AW-1:0] tlbl_waddr;
  logic [DW-1:0] tlbl_din;
  logic          tlbl_we;
  logic [AW-1:0] tlbh_waddr;
  logic [DW-1:0] tlbh_din;
  logic          tlbh_we;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          done;
    logic          busy;
    logic          stall;
    logic          hwe;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  ncpu32k_itlb_maint #(
    .CONFIG_ITLB_NSETS_LOG2(2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_valid      (flush_valid),
    .flush_ready      (flush_ready),
    .flush_done       (flush_done),
    .busy             (busy),
    .wr_stall         (wr_stall),
    .msr_imm_tlbl_idx (msr_imm_tlbl_idx),
    .msr_imm_tlbl_nxt (msr_imm_tlbl_nxt),
    .msr_imm_tlbl_we  (msr_imm_tlbl_we),
    .msr_imm_tlbh_idx (msr_imm_tlbh_idx),
    .msr_imm_tlbh_nxt (msr_imm_tlbh_nxt),
    .msr_imm_tlbh_we  (msr_imm_tlbh_we),
    .tlbl_waddr       (tlbl_waddr),
    .tlbl_din         (tlbl_din),
    .tlbl_we          (tlbl_we),
    .tlbh_waddr       (tlbh_waddr),
    .tlbh_din         (tlbh_din),
    .tlbh_we          (tlbh_we)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] obs = {tlbl_we, tlbl_waddr, tlbl_din, flush_done, busy,
                       flush_ready, wr_stall, tlbh_we, tlbh_waddr, tlbh_din};

  function automatic logic [OW-1:0] pack(exp_t x);
    return {x.we, x.a, x.d, x.done, x.busy, ~x.busy, x.stall,
            x.hwe, x.ha, x.hd};
  endfunction

  function automatic exp_t mk(logic we, int a, logic [DW-1:0] d,
                              logic done, logic bz, logic stall);
    exp_t x;
    x.we = we; x.a = AW'(a); x.d = d;
    x.done = done; x.busy = bz; x.stall = stall;
    x.hwe = 1'b0; x.ha = '0; x.hd = '0;
    return x;
  endfunction

  task automatic clr();
    flush_valid      = 1'b0;
    msr_imm_tlbl_idx = '0;
    msr_imm_tlbl_nxt = '0;
    msr_imm_tlbl_we  = 1'b0;
    msr_imm_tlbh_idx = '0;
    msr_imm_tlbh_nxt = '0;
    msr_imm_tlbh_we  = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    #2;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    checks++;
    if (obs !== pack(e)) begin
      errors++;
      $display("FAIL reset got=%h want=%h", obs, pack(e));
    end
    #6 rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      sb.push_back(mk(0, 0, 0, 0, 0, 0));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clr();
      flush_valid = (c == 0);
      if (c >= 1 && c <= 4)
        sb.push_back(mk(1, c - 1, 0, c == 4, 1, 0));
      else
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL sweep c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
  endtask

  task automatic test_passthru();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      clr();
      if (c == 0) begin
        msr_imm_tlbl_idx = AW'(2);
        msr_imm_tlbl_nxt = 32'h8000_0001;
        msr_imm_tlbl_we  = 1'b1;
        msr_imm_tlbh_idx = AW'(1);
        msr_imm_tlbh_nxt = 32'hCAFE_0002;
        msr_imm_tlbh_we  = 1'b1;
        e = mk(1, 2, 32'h8000_0001, 0, 0, 0);
        e.hwe = 1'b1; e.ha = AW'(1); e.hd = 32'hCAFE_0002;
        sb.push_back(e);
      end else begin
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
      end
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL passthru c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
  endtask

  task automatic test_buffered();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      clr();
      flush_valid = (c == 0);
      if (c == 2) begin
        msr_imm_tlbl_idx = AW'(3);
        msr_imm_tlbl_nxt = 32'h1234_5001;
        msr_imm_tlbl_we  = 1'b1;
      end
      if (c == 3) begin
        msr_imm_tlbh_idx = AW'(2);
        msr_imm_tlbh_nxt = 32'h0000_0055;
        msr_imm_tlbh_we  = 1'b1;
      end
      if (c >= 1 && c <= 4)
        e = mk(1, c - 1, 0, c == 4, 1, c >= 3);
      else if (c == 5)
        e = mk(1, 3, 32'h1234_5001, 0, 1, 1);
      else
        e = mk(0, 0, 0, 0, 0, 0);
      if (c == 3) begin
        e.hwe = 1'b1; e.ha = AW'(2); e.hd = 32'h0000_0055;
      end
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL buffered c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
  endtask

  task automatic test_same_cycle();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clr();
      if (c == 0) begin
        flush_valid      = 1'b1;
        msr_imm_tlbl_idx = AW'(1);
        msr_imm_tlbl_nxt = 32'hAAAA_0001;
        msr_imm_tlbl_we  = 1'b1;
        sb.push_back(mk(1, 1, 32'hAAAA_0001, 0, 0, 0));
      end else if (c <= 4) begin
        sb.push_back(mk(1, c - 1, 0, c == 4, 1, 0));
      end else begin
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
      end
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL same_cycle c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      clr();
      flush_valid = (c == 0);
      if (c == 1) begin
        msr_imm_tlbl_idx = AW'(2);
        msr_imm_tlbl_nxt = 32'h7777_0001;
        msr_imm_tlbl_we  = 1'b1;
      end
      if (c == 0)
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
      else
        sb.push_back(mk(1, c - 1, 0, 0, 1, c == 2));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h want=%h", c, obs, pack(e));
      end
    end
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    e = sb.pop_front();
    checks++;
    if (obs !== pack(e)) begin
      errors++;
      $display("FAIL reset_mid_abort got=%h want=%h", obs, pack(e));
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      clr();
      sb.push_back(mk(0, 0, 0, 0, 0, 0));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d got=%h want=%h",
                 c, obs, pack(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      clr();
      flush_valid = (c <= 9);
      if (c >= 1 && c <= 4)
        sb.push_back(mk(1, c - 1, 0, c == 4, 1, 0));
      else if (c >= 6 && c <= 9)
        sb.push_back(mk(1, c - 6, 0, c == 9, 1, 0));
      else
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
      #1;
      e = sb.pop_front();
      checks++;
      if (obs !== pack(e)) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%h want=%h",
                 c, obs, pack(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_passthru();
    test_buffered();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
